imem_loader: RTL

Boot-time controller that fills the writable instruction memory from a byte stream before the CPU starts fetching. It accepts bytes over a valid/ready handshake and assembles them MSB-first into n-bit instruction words. Each word is written to sequential addresses starting at 0. The CPU is held stalled while a load is in progress. The block sits between the host/debug byte link and the instruction memory write port.

---
 rtl/imem_loader_if.sv | 35 +++
 rtl/imem_loader.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus between the host link, the loader and IMEM.
interface imem_loader_if #(
    parameter int unsigned N = 16,
    parameter int unsigned R = 3
);
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic         we;
    logic [R-1:0] waddr;
    logic [N-1:0] wdata;

    // Loader side: consumes bytes, drives the memory write port
    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready,
        output we,
        output waddr,
        output wdata
    );

    // Host/memory side: produces bytes, observes the write port
    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready,
        input  we,
        input  waddr,
        input  wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: packs an MSB-first byte stream into N-bit words and writes
// them to IMEM from address 0 while holding the CPU stalled.
module imem_loader #(
    parameter int unsigned N = 16,
    parameter int unsigned R = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    imem_loader_if.slave       bus,
    output logic               o_cpu_stall,
    output logic               o_done,
    output logic [R:0]         o_word_count,
    output logic               o_err
);
    localparam int unsigned BPW = N / 8;
    localparam int unsigned BW  = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [N-1:0]  r_asm;
    logic [BW-1:0] r_byte_idx;
    logic [R-1:0]  r_addr;
    logic [R:0]    r_word_count;
    logic          r_err;
    logic          r_last_seen;
    logic          r_in_ready;
    logic          r_we;
    logic [R-1:0]  r_waddr;
    logic [N-1:0]  r_wdata;
    logic          r_cpu_stall;
    logic          r_done;

    logic [1:0]    w_state_nxt;
    logic [N-1:0]  w_asm_nxt;
    logic [BW-1:0] w_byte_idx_nxt;
    logic [R-1:0]  w_addr_nxt;
    logic [R:0]    w_word_count_nxt;
    logic          w_err_nxt;
    logic          w_last_seen_nxt;

    // Next-state and datapath update for the load session
    always_comb begin
        w_state_nxt      = r_state;
        w_asm_nxt        = r_asm;
        w_byte_idx_nxt   = r_byte_idx;
        w_addr_nxt       = r_addr;
        w_word_count_nxt = r_word_count;
        w_err_nxt        = r_err;
        w_last_seen_nxt  = r_last_seen;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt      = ST_LOAD;
                    w_asm_nxt        = '0;
                    w_byte_idx_nxt   = '0;
                    w_addr_nxt       = '0;
                    w_word_count_nxt = '0;
                    w_err_nxt        = 1'b0;
                    w_last_seen_nxt  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (bus.in_valid) begin
                    w_asm_nxt       = N'({r_asm, bus.in_data});
                    w_byte_idx_nxt  = r_byte_idx + 1'b1;
                    w_last_seen_nxt = bus.in_last;
                    if (r_byte_idx == BW'(BPW - 1)) begin
                        w_state_nxt = ST_WRITE;
                    end else if (bus.in_last) begin
                        // Truncated final word: drop it and flag the session
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_WRITE: begin
                w_word_count_nxt = r_word_count + 1'b1;
                w_byte_idx_nxt   = '0;
                if (r_last_seen) begin
                    w_state_nxt = ST_DONE;
                end else if (r_addr == {R{1'b1}}) begin
                    // Memory full without a terminating byte
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_addr_nxt  = r_addr + 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs (decoded from the next state)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_asm        <= '0;
            r_byte_idx   <= '0;
            r_addr       <= '0;
            r_word_count <= '0;
            r_err        <= 1'b0;
            r_last_seen  <= 1'b0;
            r_in_ready   <= 1'b0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_cpu_stall  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_asm        <= w_asm_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_addr       <= w_addr_nxt;
            r_word_count <= w_word_count_nxt;
            r_err        <= w_err_nxt;
            r_last_seen  <= w_last_seen_nxt;
            r_in_ready   <= (w_state_nxt == ST_LOAD);
            r_we         <= (w_state_nxt == ST_WRITE);
            r_cpu_stall  <= (w_state_nxt != ST_IDLE);
            r_done       <= (w_state_nxt == ST_DONE);
            if (w_state_nxt == ST_WRITE) begin
                r_waddr <= w_addr_nxt;
                r_wdata <= w_asm_nxt;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.we        = r_we;
    assign bus.waddr     = r_waddr;
    assign bus.wdata     = r_wdata;
    assign o_cpu_stall   = r_cpu_stall;
    assign o_done        = r_done;
    assign o_word_count  = r_word_count;
    assign o_err         = r_err;
endmodule
